// File: rtl/mpc_next_addr_if.sv
// Port bundle between the MIR/datapath side and the micro-program-counter next-address unit.
// The unit takes the slave modport; the MIR/datapath side drives through the master modport.
interface mpc_next_addr_if #(
    parameter int ADDR_W      = 9,
    parameter int MBR_W       = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] NEXT_ADDR;
    logic              JAMN;
    logic              JAMZ;
    logic              JMPC;
    logic              N_in;
    logic              Z_in;
    logic [MBR_W-1:0]  MBR;
    logic              STALL;
    logic              CALL;
    logic              RET;
    logic [ADDR_W-1:0] MPC;
    logic              N_lat;
    logic              Z_lat;
    logic [LVL_W-1:0]  STK_LVL;
    logic              STK_ERR;

    modport master (
        output NEXT_ADDR, JAMN, JAMZ, JMPC, N_in, Z_in, MBR, STALL, CALL, RET,
        input  MPC, N_lat, Z_lat, STK_LVL, STK_ERR
    );

    modport slave (
        input  NEXT_ADDR, JAMN, JAMZ, JMPC, N_in, Z_in, MBR, STALL, CALL, RET,
        output MPC, N_lat, Z_lat, STK_LVL, STK_ERR
    );
endinterface

// File: rtl/mpc_next_addr_unit.sv
// Registered MPC next-address generator: NEXT_ADDR merged with JAMN/JAMZ/JMPC, stall hold.
// Optional CALL/RET return stack enabled by defining MPC_CALL_STACK_EN.
module mpc_next_addr_unit #(
    parameter int ADDR_W      = 9,
    parameter int MBR_W       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    mpc_next_addr_if.slave    bus
);
    localparam int                LVL_W  = $clog2(STACK_DEPTH + 1);
    localparam logic [ADDR_W-1:0] RST_A  = ADDR_W'(RESET_ADDR);

    logic              hi_s;
    logic [ADDR_W-2:0] lo_s;
    logic [ADDR_W-2:0] mbr_ext_s;
    logic [ADDR_W-1:0] nxt_s;
    logic [ADDR_W-1:0] mpc_r;
    logic              n_lat_r;
    logic              z_lat_r;

    // Next-address merge from the current MIR fields and ALU flags
    always_comb begin
        mbr_ext_s = (ADDR_W-1)'(bus.MBR);
        hi_s      = bus.NEXT_ADDR[ADDR_W-1] | (bus.JAMZ & bus.Z_in) | (bus.JAMN & bus.N_in);
        if (bus.JMPC) begin
            lo_s = bus.NEXT_ADDR[ADDR_W-2:0] | mbr_ext_s;
        end else begin
            lo_s = bus.NEXT_ADDR[ADDR_W-2:0];
        end
        nxt_s = {hi_s, lo_s};
    end

`ifdef MPC_CALL_STACK_EN
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stack_r [STACK_DEPTH];
    logic [LVL_W-1:0]  lvl_r;
    logic              err_r;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic [IDX_W-1:0]  push_idx_s;
    logic [IDX_W-1:0]  top_idx_s;

    // Stack occupancy decode and push/pop pointers
    always_comb begin
        full_s     = (lvl_r == LVL_W'(STACK_DEPTH));
        empty_s    = (lvl_r == {LVL_W{1'b0}});
        push_s     = rst_n & ~bus.STALL & bus.CALL & ~bus.RET & ~full_s;
        push_idx_s = IDX_W'(lvl_r);
        top_idx_s  = IDX_W'(lvl_r - LVL_W'(1));
    end

    // Return-address storage; contents are don't-care after reset so no reset here
    always_ff @(posedge clk) begin
        if (push_s) begin
            stack_r[push_idx_s] <= mpc_r + ADDR_W'(1);
        end else begin
            stack_r[push_idx_s] <= stack_r[push_idx_s];
        end
    end

    // MPC, latched flags, stack level and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpc_r   <= RST_A;
            n_lat_r <= 1'b0;
            z_lat_r <= 1'b0;
            lvl_r   <= {LVL_W{1'b0}};
            err_r   <= 1'b0;
        end else if (bus.STALL) begin
            mpc_r   <= mpc_r;
            n_lat_r <= n_lat_r;
            z_lat_r <= z_lat_r;
            lvl_r   <= lvl_r;
            err_r   <= err_r;
        end else begin
            n_lat_r <= bus.N_in;
            z_lat_r <= bus.Z_in;
            case ({bus.CALL, bus.RET})
                2'b10: begin
                    mpc_r <= nxt_s;
                    if (full_s) begin
                        err_r <= 1'b1;
                    end else begin
                        lvl_r <= lvl_r + LVL_W'(1);
                    end
                end
                2'b01: begin
                    // RET ignores every MIR address field
                    if (empty_s) begin
                        mpc_r <= RST_A;
                        err_r <= 1'b1;
                    end else begin
                        mpc_r <= stack_r[top_idx_s];
                        lvl_r <= lvl_r - LVL_W'(1);
                    end
                end
                2'b11: begin
                    mpc_r <= nxt_s;
                    err_r <= 1'b1;
                end
                default: begin
                    mpc_r <= nxt_s;
                end
            endcase
        end
    end

    assign bus.STK_LVL = lvl_r;
    assign bus.STK_ERR = err_r;
`else
    logic unused_call_ret_s;

    // MPC and latched flags; CALL/RET have no effect in this build
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpc_r   <= RST_A;
            n_lat_r <= 1'b0;
            z_lat_r <= 1'b0;
        end else if (bus.STALL) begin
            mpc_r   <= mpc_r;
            n_lat_r <= n_lat_r;
            z_lat_r <= z_lat_r;
        end else begin
            mpc_r   <= nxt_s;
            n_lat_r <= bus.N_in;
            z_lat_r <= bus.Z_in;
        end
    end

    assign unused_call_ret_s = bus.CALL ^ bus.RET;
    assign bus.STK_LVL       = {LVL_W{1'b0}};
    assign bus.STK_ERR       = 1'b0;
`endif

    assign bus.MPC   = mpc_r;
    assign bus.N_lat = n_lat_r;
    assign bus.Z_lat = z_lat_r;
endmodule
